energy_accum_stream: RTL and testbench

- Streaming fixed-point |h|^2 accumulator. Sums real^2 + imag^2 over a block of 1..MAX_LEN complex samples and emits one saturated N-bit energy per block.
- Sits between the channel-estimate stream and the detector/metric stage.
- Generalises the fixed 8-sample energy block with:
  - a run-time block length and early termination via in_last;
  - valid/ready handshakes with backpressure on both sides;
  - a synchronous flush;
  - saturation flagging and a sample-count output.

---
 rtl/energy_accum_stream_pkg.sv | 34 +++
 rtl/energy_accum_stream_if.sv | 26 ++
 rtl/cplx_mag_sq.sv | 19 +
 rtl/energy_accum_stream.sv | 157 +++++++++++++++
 tb/tb_energy_accum_stream.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/energy_accum_stream_pkg.sv
// Shared types, width helpers and the saturation function for the energy accumulator.
// Also used by the metric blocks that reuse cplx_mag_sq.
package energy_accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // The saturation helper uses fixed maximum widths so that one function serves every N.
    localparam int SAT_MAX_W = 64;
    localparam int ACC_MAX_W = 160;

    function automatic int acc_w(input int n, input int max_len);
        return 2 * n + 1 + $clog2(max_len + 1);
    endfunction

    function automatic int sq_w(input int n, input int q);
        return 2 * n - q;
    endfunction

    // Returns {sat flag, value}; the value sits in the low n bits.
    function automatic logic [SAT_MAX_W:0] sat_to_n(input logic [ACC_MAX_W-1:0] acc, input int n);
        logic [ACC_MAX_W-1:0] lim;
        lim = (ACC_MAX_W'(1) << (n - 1)) - ACC_MAX_W'(1);
        if (acc > lim) begin
            return {1'b1, lim[SAT_MAX_W-1:0]};
        end else begin
            return {1'b0, acc[SAT_MAX_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/energy_accum_stream_if.sv
// Sample-in / energy-out handshake bundle of the energy accumulator.
interface energy_accum_stream_if #(
    parameter int N     = 16,
    parameter int LEN_W = 5
) ();
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_real;
    logic signed [N-1:0] in_im;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_data;
    logic                out_sat;
    logic [LEN_W-1:0]    out_count;

    modport master (
        output in_valid, in_real, in_im, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_real, in_im, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/cplx_mag_sq.sv
// Combinational |x|^2 in Q format: (re^2 >>> Q) + (im^2 >>> Q), squares taken at 2N bits.
module cplx_mag_sq #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic signed [N-1:0]   in_real,
    input  logic signed [N-1:0]   in_im,
    output logic [2*N-Q:0]        mag_sq
);
    localparam int E_W = 2 * N - Q + 1;

    logic signed [2*N-1:0] prod_r_s;
    logic signed [2*N-1:0] prod_i_s;

    // -2^(N-1) squared is 2^(2N-2), which still fits the signed 2N-bit product.
    assign prod_r_s = in_real * in_real;
    assign prod_i_s = in_im * in_im;
    assign mag_sq   = E_W'(prod_r_s >>> Q) + E_W'(prod_i_s >>> Q);
endmodule

// File: rtl/energy_accum_stream.sv
// Streaming |h|^2 block accumulator: sums 1..MAX_LEN samples and emits one saturated energy per block.
module energy_accum_stream
    import energy_accum_pkg::*;
#(
    parameter int Q       = 8,
    parameter int N       = 16,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             cfg_err,
    energy_accum_stream_if.slave s
);
    localparam int ACC_W = acc_w(N, MAX_LEN);
    localparam int E_W   = sq_w(N, Q) + 1;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               out_valid_q, out_valid_d;
    logic [N-1:0]       out_data_q, out_data_d;
    logic               out_sat_q, out_sat_d;
    logic [LEN_W-1:0]   out_count_q, out_count_d;
    logic               cfg_err_q, cfg_err_d;

    logic [E_W-1:0]     e_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               cfg_bad_s;
    logic               enter_hold_s;
    logic [SAT_MAX_W:0] sat_v_s;

    cplx_mag_sq #(.Q(Q), .N(N)) u_mag_sq (
        .in_real (s.in_real),
        .in_im   (s.in_im),
        .mag_sq  (e_s)
    );

    assign in_ready_s = (state_q != HOLD);
    assign accept_s   = s.in_valid & in_ready_s;
    assign cfg_bad_s  = (cfg_len == {LEN_W{1'b0}}) || (cfg_len > LEN_W'(MAX_LEN));

    // Next-state, accumulator/counter update and HOLD-entry result capture.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sat_d    = out_sat_q;
        out_count_d  = out_count_q;
        cfg_err_d    = 1'b0;
        enter_hold_s = 1'b0;
        sat_v_s      = {(SAT_MAX_W+1){1'b0}};
        if (flush) begin
            state_d     = IDLE;
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = {LEN_W{1'b0}};
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        len_d     = cfg_bad_s ? LEN_W'(MAX_LEN) : cfg_len;
                        cfg_err_d = cfg_bad_s;
                        acc_d     = ACC_W'(e_s);
                        cnt_d     = LEN_W'(1);
                        if ((len_d == LEN_W'(1)) || s.in_last) begin
                            state_d      = HOLD;
                            enter_hold_s = 1'b1;
                        end else begin
                            state_d = ACC;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACC: begin
                    if (accept_s) begin
                        acc_d = acc_q + ACC_W'(e_s);
                        cnt_d = cnt_q + LEN_W'(1);
                        if ((cnt_d == len_q) || s.in_last) begin
                            state_d      = HOLD;
                            enter_hold_s = 1'b1;
                        end else begin
                            state_d = ACC;
                        end
                    end else begin
                        state_d = ACC;
                    end
                end
                HOLD: begin
                    if (s.out_ready) begin
                        state_d     = IDLE;
                        acc_d       = {ACC_W{1'b0}};
                        cnt_d       = {LEN_W{1'b0}};
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    acc_d       = {ACC_W{1'b0}};
                    cnt_d       = {LEN_W{1'b0}};
                    out_valid_d = 1'b0;
                end
            endcase
        end
        if (enter_hold_s) begin
            sat_v_s     = sat_to_n(ACC_MAX_W'(acc_d), N);
            out_data_d  = N'(sat_v_s);
            out_sat_d   = sat_v_s[SAT_MAX_W];
            out_count_d = cnt_d;
            out_valid_d = 1'b1;
        end else begin
            out_count_d = out_count_d;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {LEN_W{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {N{1'b0}};
            out_sat_q   <= 1'b0;
            out_count_q <= {LEN_W{1'b0}};
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign s.in_ready  = in_ready_s;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_sat   = out_sat_q;
    assign s.out_count = out_count_q;
    assign cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_energy_accum_stream.sv
// Directed bench for energy_accum_stream with hand-computed expected energies.
module tb_energy_accum_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [4:0] cfg_len;
    logic       cfg_err;
    int         total = 0;
    int         bad   = 0;

    energy_accum_stream_if #(.N(16), .LEN_W(5)) bus ();

    energy_accum_stream #(.Q(8), .N(16), .MAX_LEN(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .cfg_len (cfg_len),
        .cfg_err (cfg_err),
        .s       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic signed [15:0] re, input logic signed [15:0] im,
                        input logic last);
        bus.in_valid = v;
        bus.in_real  = re;
        bus.in_im    = im;
        bus.in_last  = last;
        @(posedge clk);
        #1;
    endtask

    // Sends n samples; last_at (1-based) raises in_last, gaps inserts an idle cycle carrying in_last=1.
    task automatic run_block(input string tag, input int n, input logic signed [15:0] re,
                             input logic signed [15:0] im, input int last_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) chk({tag, "_early_valid"}, 64'(bus.out_valid), 64'd0);
            step(1'b1, re, im, (i + 1 == last_at));
            if (gaps && (i != n - 1)) step(1'b0, re, im, 1'b1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [63:0] d, input logic [63:0] sat,
                             input logic [63:0] cnt);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"},  64'(bus.out_data),  d);
        chk({tag, "_sat"},   64'(bus.out_sat),   sat);
        chk({tag, "_count"}, 64'(bus.out_count), cnt);
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        step(1'b0, 16'sd0, 16'sd0, 1'b0);
        chk({tag, "_rel_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_rel_ready"}, 64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; cfg_len = 5'd8;
        bus.in_valid = 1'b0; bus.in_real = 16'sd0; bus.in_im = 16'sd0;
        bus.in_last = 1'b0; bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_sat",   64'(bus.out_sat),   64'd0);
        chk("rst_out_count", 64'(bus.out_count), 64'd0);
        chk("rst_cfg_err",   64'(cfg_err),       64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // 8 x (256,0): 256 each -> 2048
        cfg_len = 5'd8; bus.out_ready = 1'b1;
        run_block("t1", 8, 16'sd256, 16'sd0, 0, 1'b0);
        check_out("t1", 64'd2048, 64'd0, 64'd8);
        release_out("t1");

        // 4 x (-512,256): 1024+256 each -> 5120; in_last on sample 4 is redundant
        cfg_len = 5'd4;
        run_block("t2", 4, -16'sd512, 16'sd256, 4, 1'b0);
        check_out("t2", 64'd5120, 64'd0, 64'd4);
        release_out("t2");
        run_block("t2g", 4, -16'sd512, 16'sd256, 0, 1'b1);
        check_out("t2g", 64'd5120, 64'd0, 64'd4);
        release_out("t2g");

        // early termination on sample 3 of 8: 3 x 512 -> 1536
        cfg_len = 5'd8;
        run_block("t3", 3, 16'sd256, 16'sd256, 3, 1'b0);
        check_out("t3", 64'd1536, 64'd0, 64'd3);
        release_out("t3");

        // cfg_len=0 -> MAX_LEN=16; mid-block cfg_len change ignored; 16 x 256 -> 4096
        cfg_len = 5'd0;
        step(1'b1, 16'sd256, 16'sd0, 1'b0);
        chk("t4_cfg_err_pulse", 64'(cfg_err), 64'd1);
        cfg_len = 5'd2;
        step(1'b1, 16'sd256, 16'sd0, 1'b0);
        chk("t4_cfg_err_clear", 64'(cfg_err), 64'd0);
        run_block("t4", 14, 16'sd256, 16'sd0, 0, 1'b0);
        check_out("t4", 64'd4096, 64'd0, 64'd16);
        release_out("t4");

        // saturation boundaries
        cfg_len = 5'd1;
        run_block("t5a", 1, 16'sh7FFF, 16'sd0, 0, 1'b0);
        check_out("t5a", 64'd32767, 64'd1, 64'd1);
        release_out("t5a");
        run_block("t5b", 1, -16'sd32768, 16'sd0, 0, 1'b0);
        check_out("t5b", 64'd32767, 64'd1, 64'd1);
        release_out("t5b");
        run_block("t5c", 1, 16'sd2896, 16'sd0, 0, 1'b0);
        check_out("t5c", 64'd32761, 64'd0, 64'd1);
        release_out("t5c");

        // backpressure: result held 5 cycles while a sample waits
        run_block("t6", 1, 16'sd256, 16'sd0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'sd512, 16'sd0, 1'b0);
            chk("t6_hold_ready", 64'(bus.in_ready),  64'd0);
            chk("t6_hold_data",  64'(bus.out_data),  64'd256);
            chk("t6_hold_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        step(1'b1, 16'sd512, 16'sd0, 1'b0);
        chk("t6_drain_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_drain_ready", 64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b0;
        step(1'b1, 16'sd512, 16'sd0, 1'b0);
        bus.in_valid = 1'b0;
        check_out("t6_next", 64'd1024, 64'd0, 64'd1);
        release_out("t6");

        // flush after 5 of 8, sample in the flush cycle dropped, then clean block
        cfg_len = 5'd8;
        for (int i = 0; i < 5; i++) step(1'b1, 16'sd256, 16'sd0, 1'b0);
        flush = 1'b1;
        step(1'b1, 16'sd1024, 16'sd0, 1'b0);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("t7_flush_valid", 64'(bus.out_valid), 64'd0);
        run_block("t7", 8, 16'sd256, 16'sd0, 0, 1'b0);
        check_out("t7", 64'd2048, 64'd0, 64'd8);
        release_out("t7");

        // flush discards a held result
        cfg_len = 5'd1;
        run_block("t7h", 1, 16'sd256, 16'sd0, 0, 1'b0);
        flush = 1'b1;
        step(1'b0, 16'sd0, 16'sd0, 1'b0);
        flush = 1'b0;
        chk("t7h_valid", 64'(bus.out_valid), 64'd0);
        chk("t7h_ready", 64'(bus.in_ready),  64'd1);

        // async reset while in HOLD
        run_block("t8", 1, 16'sd256, 16'sd0, 0, 1'b0);
        chk("t8_pre_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t8_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t8_rst_data",  64'(bus.out_data),  64'd0);
        chk("t8_rst_sat",   64'(bus.out_sat),   64'd0);
        chk("t8_rst_count", 64'(bus.out_count), 64'd0);
        chk("t8_rst_ready", 64'(bus.in_ready),  64'd1);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
